i2c_master_cmd: RTL and testbench
=================================

// Module: i2c_master_cmd
// PURPOSE
//  Parametrised command-driven I2C master: byte-level START / WRITE / READ / STOP
//  commands over a valid/ready interface, open-drain SCL and SDA, clock stretching,
//  repeated start and multi-byte reads and writes with per-byte ACK/NACK control.
//  Sits between a local controller FSM and the board I2C pins, which have external pull-ups.
// PARAMETERS
//  CLK_DIV  250  clk cycles per SCL quarter-period (SCL period = 4*CLK_DIV); legal >= 2
// PORTS
//  clk        in     1  system clock
//  rst        in     1  synchronous reset, active-low
//  cmd_valid  in     1  command present
//  cmd_ready  out    1  block can accept a command
//  cmd        in     2  00 START (or repeated START), 01 WRITE, 10 READ, 11 STOP
//  cmd_data   in     8  byte for WRITE, MSB first
//  cmd_ack    in     1  READ only: 1 = master ACKs (drives SDA low on bit 9), 0 = NACK
//  rd_data    out    8  last byte read
//  rd_valid   out    1  1-cycle pulse when rd_data updates
//  ack_rcvd   out    1  1 = slave ACKed the last WRITE
//  cmd_err    out    1  1-cycle pulse: WRITE/READ/STOP issued while the bus is not active
//  busy       out    1  a command is executing
//  bus_active out    1  START done, no STOP yet
//  scl        inout  1  open drain: drive 0 or release (Z); sampled as input
//  sda        inout  1  open drain: drive 0 or release (Z); sampled as input
// BEHAVIOUR
//  Reset (rst=0 at clk edge): SCL and SDA released, cmd_ready=1, busy=0, bus_active=0,
//   rd_data=0, rd_valid=0, ack_rcvd=0, cmd_err=0, divider and bit counters cleared.
//   Reset mid-transfer: lines released on the next edge. No STOP is generated.
//  Handshake: a command is accepted when cmd_valid & cmd_ready. cmd_ready drops the next
//   cycle and busy rises. cmd_data and cmd_ack are latched at accept.
//   cmd_ready=1 and busy=0 return on the cycle after the last quarter completes.
//  Timebase: the quarter counter counts CLK_DIV clocks per quarter. Every phase has 4 quarters Q0..Q3.
//   The quarter in which SCL is released does not end until scl samples 1
//   (clock stretching); its CLK_DIV count starts once scl is high.
//  States: IDLE, START, BIT, STOP, HOLD. The bus is held with SCL driven low between commands.
//   START : Q0 release SDA; Q1 release SCL (stretch); Q2 drive SDA 0; Q3 drive SCL 0.
//           From IDLE the lines are already high. From HOLD this forms a repeated START.
//           Sets bus_active at completion.
//   WRITE : 9 bits. Per bit: Q0 SCL low, SDA set (bits 1-8 = cmd_data[7..0], bit 9 released);
//           Q1 release SCL (stretch); Q2 SCL high, SDA sampled on the last clk of Q2;
//           Q3 drive SCL 0. ack_rcvd = ~sampled bit 9 at completion.
//           A NACK does not abort: the bus stays active and the controller decides what follows.
//   READ  : 9 bits, same timing. Bits 1-8: SDA released and sampled MSB first into a shift register.
//           Bit 9: SDA driven 0 if cmd_ack else released.
//           rd_data updates and rd_valid pulses on the completion cycle.
//   STOP  : Q0 drive SDA 0; Q1 release SCL (stretch); Q2 release SDA; Q3 bus-free hold.
//           Clears bus_active at completion, then IDLE.
//  Latency with no stretching: START/STOP 4*CLK_DIV clks; WRITE/READ 36*CLK_DIV clks.
//  cmd_err: WRITE/READ/STOP accepted with bus_active=0 -> one cycle busy, cmd_err pulse,
//   no line activity. START with bus_active=1 is legal (repeated START).
//  SDA changes only while SCL is driven low, except in the START and STOP conditions.
//  ack_rcvd and rd_data hold their value until overwritten.
// TESTING (CLK_DIV=4)
//  Reset: rst=0 for 3 clks mid-WRITE -> scl/sda read 1 (pulled up) next clk, cmd_ready=1, busy=0, bus_active=0.
//  START, WRITE 0xA4 with slave ACK, STOP -> SDA on SCL highs 1,0,1,0,0,1,0,0.
//   ack_rcvd=1. WRITE busy 144 clks. SDA rises while SCL is high at the STOP.
//  WRITE 0x3C with no slave (SDA floats 1) -> ack_rcvd=0, bus_active stays 1, following STOP completes.
//  READ with slave sending 0x5A, cmd_ack=1 then READ 0xC3, cmd_ack=0 -> rd_data 0x5A then 0xC3,
//   one rd_valid pulse each, SDA 0 then released on the respective bit 9.
//  Slave holds SCL low 20 clks during bit 3 of a WRITE -> completion 20 clks later, data bits unchanged.
//  WRITE issued from IDLE -> cmd_err pulse, no SCL edge. START, START (repeated) -> SDA falls while SCL is high both times.

Source files
------------

// File: rtl/i2c_master_cmd.sv
// Command-driven I2C master: byte-level START / WRITE / READ / STOP over valid/ready,
// open-drain SCL/SDA with clock stretching, repeated start and per-byte ACK control.
module i2c_master_cmd #(
   parameter int unsigned CLK_DIV = 250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd,
   input  logic [7:0] cmd_data,
   input  logic       cmd_ack,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       ack_rcvd,
   output logic       cmd_err,
   output logic       busy,
   output logic       bus_active,
   inout  wire        scl,
   inout  wire        sda
);

   localparam int unsigned           CW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0]         CNT_MAX = CW'(CLK_DIV - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_HOLD, S_ERR} state_t;
   typedef enum logic [1:0] {C_START = 2'b00, C_WRITE = 2'b01, C_READ = 2'b10, C_STOP = 2'b11} cmd_t;

   state_t        state, state_nxt;
   logic [1:0]    qtr, qtr_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [3:0]    bit_idx, bit_nxt;
   logic          is_read, is_read_nxt;
   logic [7:0]    tx_byte, tx_nxt;
   logic          ack_q, ack_nxt;
   logic [7:0]    shreg;
   logic          nack_bit;
   logic          scl_oe, sda_oe, scl_oe_nxt, sda_oe_nxt;
   logic          accept, phase_done, sample;
   logic [2:0]    bsel;
   logic          sda_bit_low;
   logic          scl_in, sda_in;

   // Open drain: the only values ever put on the pins are 0 and Z.
   assign scl    = scl_oe ? 1'b0 : 1'bz;
   assign sda    = sda_oe ? 1'b0 : 1'bz;
   assign scl_in = scl;
   assign sda_in = sda;

   assign cmd_ready = (state == S_IDLE) || (state == S_HOLD);
   assign busy      = ~cmd_ready;
   assign cmd_err   = (state == S_ERR);
   assign accept    = cmd_valid & cmd_ready;

   // Next state, quarter timebase and bit position.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
      state_nxt   = state;
      qtr_nxt     = qtr;
      cnt_nxt     = cnt;
      bit_nxt     = bit_idx;
      is_read_nxt = is_read;
      tx_nxt      = tx_byte;
      ack_nxt     = ack_q;
      phase_done  = 1'b0;
      sample      = 1'b0;
      case (state)
         S_IDLE, S_HOLD: begin
            if (accept) begin
               qtr_nxt     = '0;
               cnt_nxt     = '0;
               bit_nxt     = '0;
               is_read_nxt = (cmd == C_READ);
               tx_nxt      = cmd_data;
               ack_nxt     = cmd_ack;
               if (cmd == C_START)      state_nxt = S_START;
               else if (!bus_active)    state_nxt = S_ERR;
               else if (cmd == C_STOP)  state_nxt = S_STOP;
               else                     state_nxt = S_BIT;
            end
         end
         S_ERR: state_nxt = S_IDLE;
         default: begin
            // Quarter 1 releases SCL; its count only runs while the line is really high.
            if (qtr == 2'd1 && !scl_in) begin
               cnt_nxt = '0;
            end else if (cnt == CNT_MAX) begin
               cnt_nxt = '0;
               qtr_nxt = qtr + 2'd1;
               sample  = (state == S_BIT) && (qtr == 2'd2);
               if (qtr == 2'd3) begin
                  if (state == S_BIT && bit_idx != 4'd8) begin
                     bit_nxt = bit_idx + 4'd1;
                  end else begin
                     phase_done = 1'b1;
                     state_nxt  = (state == S_STOP) ? S_IDLE : S_HOLD;
                  end
               end
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
      endcase
   end

   // Line drive is decoded from the next state so the pins change on the quarter boundary itself.
   always_comb begin
      scl_oe_nxt = scl_oe;
      sda_oe_nxt = sda_oe;
      bsel       = 3'd7 - bit_nxt[2:0];
      if (bit_nxt == 4'd8) sda_bit_low = is_read_nxt & ack_nxt;
      else                 sda_bit_low = ~is_read_nxt & ~tx_nxt[bsel];
      case (state_nxt)
         S_IDLE: begin
            scl_oe_nxt = 1'b0;
            sda_oe_nxt = 1'b0;
         end
         S_HOLD: scl_oe_nxt = 1'b1;
         S_START: begin
            case (qtr_nxt)
               2'd0:    sda_oe_nxt = 1'b0;
               2'd1:    scl_oe_nxt = 1'b0;
               2'd2:    sda_oe_nxt = 1'b1;
               default: scl_oe_nxt = 1'b1;
            endcase
         end
         S_BIT: begin
            scl_oe_nxt = (qtr_nxt == 2'd0) || (qtr_nxt == 2'd3);
            sda_oe_nxt = sda_bit_low;
         end
         S_STOP: begin
            case (qtr_nxt)
               2'd0:    sda_oe_nxt = 1'b1;
               2'd1:    scl_oe_nxt = 1'b0;
               2'd2:    sda_oe_nxt = 1'b0;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         qtr        <= '0;
         cnt        <= '0;
         bit_idx    <= '0;
         is_read    <= 1'b0;
         tx_byte    <= '0;
         ack_q      <= 1'b0;
         shreg      <= '0;
         nack_bit   <= 1'b1;
         scl_oe     <= 1'b0;
         sda_oe     <= 1'b0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
         ack_rcvd   <= 1'b0;
         bus_active <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state    <= state_nxt;
         qtr      <= qtr_nxt;
         cnt      <= cnt_nxt;
         bit_idx  <= bit_nxt;
         is_read  <= is_read_nxt;
         tx_byte  <= tx_nxt;
         ack_q    <= ack_nxt;
         scl_oe   <= scl_oe_nxt;
         sda_oe   <= sda_oe_nxt;
         rd_valid <= 1'b0;
         if (sample) begin
            if (bit_idx == 4'd8) nack_bit <= sda_in;
            else                 shreg    <= {shreg[6:0], sda_in};
         end
         if (phase_done) begin
            case (state)
               S_START: bus_active <= 1'b1;
               S_STOP:  bus_active <= 1'b0;
               S_BIT: begin
                  if (is_read) begin
                     rd_data  <= shreg;
                     rd_valid <= 1'b1;
                  end else begin
                     ack_rcvd <= ~nack_bit;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_master_cmd.sv
// Self-checking bench for i2c_master_cmd: bus monitor plus byte-level slave model,
// directed scenarios and randomized command sequences against a transaction-level model.
module tb_i2c_master_cmd;

   localparam int CD      = 4;
   localparam int STRETCH = 20;
   localparam int TIMEOUT = 2000;

   localparam logic [1:0] OP_START = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_STOP  = 2'b11;

   typedef enum {SLV_NONE, SLV_ACK, SLV_READ} slv_mode_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd = 2'b00;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_ack = 1'b0;
   logic       cmd_ready, rd_valid, ack_rcvd, cmd_err, busy, bus_active;
   logic [7:0] rd_data;
   wire        scl, sda;

   i2c_master_cmd #(.CLK_DIV(CD)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd        (cmd),
      .cmd_data   (cmd_data),
      .cmd_ack    (cmd_ack),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .ack_rcvd   (ack_rcvd),
      .cmd_err    (cmd_err),
      .busy       (busy),
      .bus_active (bus_active),
      .scl        (scl),
      .sda        (sda)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Slave model and bus monitor. Control inputs are written only by the stimulus process.
   slv_mode_t  slv_mode   = SLV_NONE;
   logic [7:0] slv_byte   = 8'h00;
   int         falls_base = 0;
   bit         str_armed  = 1'b0;

   logic scl_p = 1'b1;
   logic sda_p = 1'b1;
   logic mon_bits[$];
   int   n_start = 0, n_stop = 0, n_scl_edges = 0, falls = 0, str_left = 0;
   int   rel;
   logic slv_sda_low, slv_scl_low;

   pullup (scl);
   pullup (sda);
   assign scl = slv_scl_low ? 1'b0 : 1'bz;
   assign sda = slv_sda_low ? 1'b0 : 1'bz;

   assign rel         = falls - falls_base;
   assign slv_scl_low = (str_left > 0);

   always_comb begin
      slv_sda_low = 1'b0;
      case (slv_mode)
         SLV_ACK:  slv_sda_low = (rel == 8);
         SLV_READ: if (rel >= 0 && rel < 8) slv_sda_low = ~slv_byte[3'(7 - rel)];
         default:  slv_sda_low = 1'b0;
      endcase
   end

   always @(negedge clk) begin
      if (scl !== scl_p) n_scl_edges++;
      if (!scl_p && scl) mon_bits.push_back(sda);
      if (scl_p && scl && sda_p && !sda) n_start++;
      if (scl_p && scl && !sda_p && sda) n_stop++;
      if (str_left > 0) str_left--;
      if (scl_p && !scl) begin
         falls++;
         if (str_armed && (falls - falls_base) == 2) str_left = STRETCH + 2 * CD;
      end
      scl_p = scl;
      sda_p = sda;
   end

   // Transaction-level reference state.
   logic       m_bus_active = 1'b0;
   logic       m_ack        = 1'b0;
   logic [7:0] m_rd         = 8'h00;

   task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] data,
                          input logic ack, input slv_mode_t mode, input logic [7:0] sbyte,
                          input bit stretch);
      bit         legal;
      int         exp_cycles, cycles, rdv, errp, b_bits, b_start, b_stop, b_edges;
      logic [8:0] got_bits, exp_bits;
      bit         first;
      legal = (op == OP_START) || m_bus_active;
      if (!legal)                             exp_cycles = 1;
      else if (op == OP_START || op == OP_STOP) exp_cycles = 4 * CD;
      else                                    exp_cycles = 36 * CD;
      if (legal && stretch) exp_cycles += STRETCH;

      @(posedge clk);
      #1;
      b_bits     = mon_bits.size();
      b_start    = n_start;
      b_stop     = n_stop;
      b_edges    = n_scl_edges;
      falls_base = falls;
      slv_byte   = sbyte;
      slv_mode   = legal ? mode : SLV_NONE;
      str_armed  = stretch;
      check($sformatf("%s.ready", tag), cmd_ready, 1);
      cmd       = op;
      cmd_data  = data;
      cmd_ack   = ack;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;

      cycles = 0;
      rdv    = 0;
      errp   = 0;
      first  = 1'b1;
      forever begin
         @(negedge clk);
         if (rd_valid) rdv++;
         if (cmd_err)  errp++;
         if (first) begin
            check($sformatf("%s.ready_busy", tag), {cmd_ready, busy}, 2'b01);
            first = 1'b0;
         end
         if (!busy || cycles > TIMEOUT) break;
         cycles++;
      end
      str_armed = 1'b0;
      slv_mode  = SLV_NONE;

      check($sformatf("%s.cycles", tag), cycles, exp_cycles);
      check($sformatf("%s.cmd_err", tag), errp, legal ? 0 : 1);
      check($sformatf("%s.rd_valid", tag), rdv, (legal && op == OP_READ) ? 1 : 0);

      if (!legal) begin
         check($sformatf("%s.scl_edges", tag), n_scl_edges - b_edges, 0);
      end else if (op == OP_START) begin
         check($sformatf("%s.start_cond", tag), n_start - b_start, 1);
         m_bus_active = 1'b1;
      end else if (op == OP_STOP) begin
         check($sformatf("%s.stop_cond", tag), n_stop - b_stop, 1);
         m_bus_active = 1'b0;
      end else begin
         check($sformatf("%s.nbits", tag), mon_bits.size() - b_bits, 9);
         got_bits = '0;
         if (mon_bits.size() - b_bits == 9)
            for (int i = 0; i < 9; i++) got_bits = {got_bits[7:0], mon_bits[b_bits + i]};
         if (op == OP_WRITE) begin
            exp_bits = {data, (mode == SLV_ACK) ? 1'b0 : 1'b1};
            m_ack    = (mode == SLV_ACK);
         end else begin
            exp_bits = {sbyte, ~ack};
            m_rd     = sbyte;
         end
         check($sformatf("%s.bits", tag), got_bits, exp_bits);
         check($sformatf("%s.no_cond", tag), (n_start - b_start) + (n_stop - b_stop), 0);
      end
      check($sformatf("%s.bus_active", tag), bus_active, m_bus_active);
      check($sformatf("%s.ack_rcvd", tag), ack_rcvd, m_ack);
      check($sformatf("%s.rd_data", tag), rd_data, m_rd);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] op;
      int         r;
      slv_mode_t  mode;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst.lines", {scl, sda}, 2'b11);
      check("rst.ready_busy", {cmd_ready, busy}, 2'b10);
      check("rst.flags", {bus_active, rd_valid, ack_rcvd, cmd_err}, 4'b0000);
      check("rst.rd_data", rd_data, 8'h00);
      rst = 1'b1;

      run_cmd("err_wr_idle", OP_WRITE, 8'h55, 1'b0, SLV_ACK, 8'h00, 1'b0);

      run_cmd("a4.start", OP_START, 8'h00, 1'b0, SLV_NONE, 8'h00, 1'b0);
      run_cmd("a4.write", OP_WRITE, 8'hA4, 1'b0, SLV_ACK,  8'h00, 1'b0);
      run_cmd("a4.stop",  OP_STOP,  8'h00, 1'b0, SLV_NONE, 8'h00, 1'b0);

      run_cmd("nack.start", OP_START, 8'h00, 1'b0, SLV_NONE, 8'h00, 1'b0);
      run_cmd("nack.write", OP_WRITE, 8'h3C, 1'b0, SLV_NONE, 8'h00, 1'b0);
      run_cmd("nack.stop",  OP_STOP,  8'h00, 1'b0, SLV_NONE, 8'h00, 1'b0);

      run_cmd("rd.start", OP_START, 8'h00, 1'b0, SLV_NONE, 8'h00, 1'b0);
      run_cmd("rd.5a",    OP_READ,  8'h00, 1'b1, SLV_READ, 8'h5A, 1'b0);
      run_cmd("rd.c3",    OP_READ,  8'h00, 1'b0, SLV_READ, 8'hC3, 1'b0);
      run_cmd("rd.stop",  OP_STOP,  8'h00, 1'b0, SLV_NONE, 8'h00, 1'b0);

      run_cmd("str.start", OP_START, 8'h00, 1'b0, SLV_NONE, 8'h00, 1'b0);
      run_cmd("str.write", OP_WRITE, 8'h96, 1'b0, SLV_ACK,  8'h00, 1'b1);
      run_cmd("rs.start",  OP_START, 8'h00, 1'b0, SLV_NONE, 8'h00, 1'b0);
      run_cmd("rs.stop",   OP_STOP,  8'h00, 1'b0, SLV_NONE, 8'h00, 1'b0);
      run_cmd("err_stop_idle", OP_STOP, 8'h00, 1'b0, SLV_NONE, 8'h00, 1'b0);

      for (int i = 0; i < 40; i++) begin
         r = int'($urandom_range(0, 9));
         if (!m_bus_active) op = (r == 0) ? 2'($urandom_range(1, 3)) : OP_START;
         else if (r < 2)    op = OP_START;
         else if (r < 5)    op = OP_WRITE;
         else if (r < 8)    op = OP_READ;
         else               op = OP_STOP;
         if (op == OP_READ)       mode = SLV_READ;
         else if (op == OP_WRITE) mode = $urandom_range(0, 1) ? SLV_ACK : SLV_NONE;
         else                     mode = SLV_NONE;
         run_cmd($sformatf("rnd%0d", i), op, 8'($urandom), 1'($urandom), mode, 8'($urandom),
                 (op == OP_WRITE) && ($urandom_range(0, 3) == 0));
      end

      // Reset in the middle of a WRITE: lines must be released right away, no STOP.
      run_cmd("mid.start", OP_START, 8'h00, 1'b0, SLV_NONE, 8'h00, 1'b0);
      @(posedge clk);
      #1;
      cmd       = OP_WRITE;
      cmd_data  = 8'h00;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid.lines", {scl, sda}, 2'b11);
      check("mid.ready_busy", {cmd_ready, busy}, 2'b10);
      check("mid.bus_active", bus_active, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      m_bus_active = 1'b0;
      m_ack        = 1'b0;
      m_rd         = 8'h00;
      @(negedge clk);
      check("mid.regs", {rd_data, ack_rcvd, rd_valid, cmd_err}, 11'h000);

      run_cmd("post.start", OP_START, 8'h00, 1'b0, SLV_NONE, 8'h00, 1'b0);
      run_cmd("post.write", OP_WRITE, 8'h81, 1'b0, SLV_ACK,  8'h00, 1'b0);
      run_cmd("post.stop",  OP_STOP,  8'h00, 1'b0, SLV_NONE, 8'h00, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
